// File: rtl/chip_pkg.sv
// Shared constants and types for the chip-path capture buffer.
// HDR_MAGIC tags the optional header word emitted ahead of the chip samples.
package chip_pkg;

  localparam int          LEN_CHIP   = 4000;
  // The selector emits chip length - 1 valid words per chip.
  localparam int          CHIP_WORDS = LEN_CHIP - 1;
  localparam int          AW_DEF     = 12;
  localparam logic [7:0]  HDR_MAGIC  = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic int chip_len_of(input int words, input bit hdr_en);
    return words + (hdr_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/chip_buf_if.sv
// Stream-in and host read-out signals of chip_buf.
// master = selector/host side, slave = the buffer itself.
interface chip_buf_if;

  // Write side: a word transfers on a rising clk_sys edge when d1_vld & buf_rdy.
  // Read side: rd_req in cycle N returns rd_data with a one-cycle rd_vld in N+1;
  // rd_req has no ready and may be held high for one read per cycle.
  logic [15:0] d1_data;
  logic        d1_vld;
  logic [6:0]  sel_path;
  logic        buf_rdy;
  logic        buf_clr;
  logic        chip_rdy;
  logic [6:0]  chip_ch;
  logic [12:0] chip_len;
  logic        rd_req;
  logic [15:0] rd_data;
  logic        rd_vld;

  modport master (
    output d1_data, d1_vld, sel_path, buf_clr, rd_req,
    input  buf_rdy, chip_rdy, chip_ch, chip_len, rd_data, rd_vld
  );

  modport slave (
    input  d1_data, d1_vld, sel_path, buf_clr, rd_req,
    output buf_rdy, chip_rdy, chip_ch, chip_len, rd_data, rd_vld
  );

endinterface

// File: rtl/chip_buf_ram.sv
// Simple dual-port 2^AW x 16 sample store with a registered read port.
module chip_buf_ram #(
  parameter int AW = 12
) (
  input  logic          clk_sys,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [15:0]   wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [15:0]   rd
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clk_sys) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/chip_buf.sv
// Chip capture buffer: fills one chip from the selector, then drains it to the host.
// Define CHIP_BUF_HDR_EN to prepend a {HDR_MAGIC, 1'b0, chip_ch} header word to each readout.
module chip_buf #(
  parameter int CHIP_WORDS = chip_pkg::CHIP_WORDS,
  parameter int AW         = chip_pkg::AW_DEF
) (
  input  logic              clk_sys,
  input  logic              rst,
  chip_buf_if.slave         bus,
  output chip_pkg::state_t  dbg_state
);

  import chip_pkg::*;

`ifdef CHIP_BUF_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  localparam int              CW      = AW + 1;
  localparam int              LEN     = chip_len_of(CHIP_WORDS, HDR_EN);
  localparam logic [CW-1:0]   WR_LAST = CW'(CHIP_WORDS - 1);
  localparam logic [CW-1:0]   RD_LAST = CW'(LEN - 1);
  localparam logic [CW-1:0]   RD_END  = CW'(LEN);

  state_t        state, state_nx;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic          buf_rdy_q, chip_rdy_q, rd_vld_q, hdr_q;
  logic [6:0]    chip_ch_q;
  logic          acc, rd_fire, rd_hdr, ram_re;
  logic [AW-1:0] ra;
  logic [15:0]   ram_q;

  always_comb begin
    acc     = bus.d1_vld & buf_rdy_q & ~bus.buf_clr &
              ((state == ST_IDLE) | (state == ST_FILL));
    rd_fire = bus.rd_req & ~bus.buf_clr & (rd_cnt != RD_END) &
              ((state == ST_FULL) | (state == ST_DRAIN));
    rd_hdr  = HDR_EN && (rd_cnt == '0);
    ram_re  = rd_fire & ~rd_hdr;
    // With the header on, sample k is read at rd_cnt = k + 1.
    ra      = rd_cnt[AW-1:0] - AW'(HDR_EN);
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (acc) state_nx = (CHIP_WORDS == 1) ? ST_FULL : ST_FILL;
      ST_FILL:  if (acc && (wr_cnt == WR_LAST)) state_nx = ST_FULL;
      ST_FULL:  if (rd_fire) state_nx = (rd_cnt == RD_LAST) ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (rd_fire && (rd_cnt == RD_LAST)) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (bus.buf_clr) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      buf_rdy_q  <= 1'b0;
      chip_rdy_q <= 1'b0;
      chip_ch_q  <= '0;
      rd_vld_q   <= 1'b0;
      hdr_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      // The final read leaves buf_rdy low for the cycle carrying the last rd_vld.
      buf_rdy_q  <= ((state_nx == ST_IDLE) || (state_nx == ST_FILL)) && !rd_fire;
      chip_rdy_q <= (state_nx == ST_FULL) || (state_nx == ST_DRAIN);
      rd_vld_q   <= rd_fire;
      hdr_q      <= rd_fire & rd_hdr;
      wr_cnt     <= (state_nx == ST_IDLE) ? '0 : wr_cnt + CW'(acc);
      rd_cnt     <= (state_nx == ST_IDLE) ? '0 : rd_cnt + CW'(rd_fire);
      if (acc && (state == ST_IDLE)) chip_ch_q <= bus.sel_path;
    end
  end

  chip_buf_ram #(.AW(AW)) u_ram (
    .clk_sys (clk_sys),
    .we      (acc),
    .wa      (wr_cnt[AW-1:0]),
    .wd      (bus.d1_data),
    .re      (ram_re),
    .ra      (ra),
    .rd      (ram_q)
  );

  assign bus.buf_rdy  = buf_rdy_q;
  assign bus.chip_rdy = chip_rdy_q;
  assign bus.chip_ch  = chip_ch_q;
  assign bus.chip_len = 13'(LEN);
  assign bus.rd_vld   = rd_vld_q;
  // rd_data is forced to zero whenever no read is being returned.
  assign bus.rd_data  = !rd_vld_q ? 16'h0000 :
                        hdr_q     ? {HDR_MAGIC, 1'b0, chip_ch_q} : ram_q;
  assign dbg_state    = state;

endmodule

// File: doc/chip_buf.md
# chip_buf

Capture buffer at the far end of the chip-path stream: accepts one chip of `d1_data` words under `buf_rdy` flow control, latches the channel index, then holds `buf_rdy` low while the host side reads the chip out word by word. It sits between the chip selector and the upload/readout logic. It returns to accepting only after the whole chip has been drained or the buffer is cleared.

## Interface
Parameters:
- `CHIP_WORDS`, 3999: words per chip; the selector emits chip length − 1 valid words. Use 9 in simulation builds.
- `AW`, 12: RAM address width; requires 2^AW ≥ CHIP_WORDS + 1.

Ports (clock and reset first):
- `clk_sys` in 1: system clock; everything is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `d1_data` in 16: chip sample from the selector.
- `d1_vld` in 1: sample valid; a word is accepted only when `d1_vld & buf_rdy`.
- `sel_path` in 7: channel index, latched on the first accepted word.
- `buf_rdy` out 1: buffer can accept words.
- `buf_clr` in 1: abort; discard contents and return to IDLE.
- `chip_rdy` out 1: a complete chip is held and not yet fully read.
- `chip_ch` out 7: latched channel of the held chip.
- `chip_len` out 13: words the host will read.
- `rd_req` in 1: read-one-word strobe.
- `rd_data` out 16: read word.
- `rd_vld` out 1: `rd_data` valid, one-cycle pulse.

## Operation
States are IDLE, FILL, FULL, DRAIN.
- **IDLE**: `buf_rdy`=1, `wr_cnt`=0. The first accepted word writes address 0, latches `sel_path` into `chip_ch`, and moves to FILL. If CHIP_WORDS=1, it goes directly to FULL.
- **FILL**: `buf_rdy`=1. Each accepted word writes address `wr_cnt` and increments `wr_cnt`. The accept at `wr_cnt`=CHIP_WORDS−1 moves to FULL. `sel_path` changes during FILL are ignored.
- **FULL**: `buf_rdy`=0 and `chip_rdy`=1. `d1_vld` is ignored. The first `rd_req` moves to DRAIN.
- **DRAIN**: each `rd_req` reads address `rd_cnt` and increments `rd_cnt`. The read returning word `chip_len`−1 moves to IDLE. `chip_rdy` drops in the same cycle that the last `rd_vld` is asserted.
- **`rd_req` handling**: ignored in IDLE and FILL, and ignored once `rd_cnt`=`chip_len`. A `rd_req` asserted while the previous read's `rd_vld` is pending is still legal, giving one read per cycle.
- **`buf_clr`**: has priority over every other event in every state. Next state is IDLE, counters reset, `chip_rdy`=0, and no `rd_vld` is issued for a read in flight.
- **Counters**: both counters are AW+1 bits and never wrap, because state transitions bound them.

## Timing
- **Reset values**: `buf_rdy`=0, `chip_rdy`=0, `rd_vld`=0, `rd_data`=0, `chip_ch`=0, `chip_len`=CHIP_WORDS (+1 with the header), state IDLE.
- **After reset**: `buf_rdy` rises on the first cycle after `rst` deasserts.
- **`buf_rdy` timing**: `buf_rdy` is registered. It is low in the cycle immediately after the final FILL accept, so the selector cannot re-trigger on the next sample. It stays high through the entire FILL, so no mid-chip stalls are generated.
- **Read latency**: `rd_req` in cycle N gives `rd_vld` and `rd_data` in cycle N+1, from a registered RAM read.
- **Returning to IDLE**: after the final `rd_vld`, `buf_rdy`=1 in the next cycle.
- **Simultaneous events**: `buf_clr` together with `rd_req`, clear wins. A `d1_vld` in the same cycle as the final accept cannot occur, because there is a single word per cycle.

## Configuration
- **`CHIP_BUF_HDR_EN` defined**: `chip_len`=CHIP_WORDS+1. The first word read in DRAIN is the header {8'hA5, 1'b0, `chip_ch`}. Sample words follow from RAM address 0, and the RAM is not read for the header cycle.
- **Undefined**: `chip_len`=CHIP_WORDS, and the first read returns address 0.

## Structure
- **Shared package `chip_pkg`**: LEN_CHIP, the derived CHIP_WORDS, state encodings, and HDR_MAGIC 8'hA5.
- **Sub-module `chip_buf_ram`**: simple dual-port 2^AW×16 inferred RAM with a registered read port. Write enable is the FILL accept; the read address is `rd_cnt`.
- **`chip_buf` itself**: holds the FSM, counters, latches and header mux.

## Test plan
All scenarios use CHIP_WORDS=9 and header off unless stated.
- **Fill then drain**: 9 words 16'h0100..16'h0108 with `sel_path`=3 → `buf_rdy` low the cycle after the 9th accept, `chip_rdy`=1, `chip_ch`=3. 9 back-to-back `rd_req` → `rd_data` 0100..0108 each one cycle later, then `buf_rdy`=1 the cycle after the last `rd_vld`.
- **Gapped input**: `d1_vld` toggling every other cycle, with `d1_vld` held while `buf_rdy`=0 before start → only words accepted under `buf_rdy` are stored, and the count is still exactly 9.
- **Ignored inputs in FULL**: `d1_vld`=1 with data FFFF for 20 cycles → no write, and the readout is unchanged. `rd_req` during IDLE and FILL → no `rd_vld`.
- **Clear mid-operation**: `buf_clr` at `wr_cnt`=4 → IDLE and `buf_rdy`=1. `buf_clr` during DRAIN with a read in flight → no `rd_vld`, and a new chip is accepted afterwards.
- **Header build**: `CHIP_BUF_HDR_EN` with `sel_path`=7 → `chip_len`=10, and the first `rd_data` is 16'hA507 followed by the 9 samples.
- **Reset mid-DRAIN**: `rst` asserted mid-DRAIN → all outputs at reset values the next cycle, and `buf_rdy`=1 one cycle after release.
